// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, state encoding and helpers for the ALU issue sequencer
package alu_pkg;

  localparam logic [3:0] ALU_HOLD_CODE = 4'b0010;

  localparam int FLG_Z  = 5;
  localparam int FLG_C  = 4;
  localparam int FLG_V  = 3;
  localparam int FLG_EQ = 2;
  localparam int FLG_GR = 1;
  localparam int FLG_LS = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } seq_state_t;

  // Any select whose low bits are 2'b10 freezes the ALU output register.
  function automatic logic is_hold_code(input logic [3:0] op);
    return op[1:0] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x DW register file, one write port, two operand reads and a debug read
module alu_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_ra_addr,
  output logic [DW-1:0] o_ra_data,
  input  logic [RW-1:0] i_rb_addr,
  output logic [DW-1:0] o_rb_data,
  input  logic [RW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issues one instruction at a time to the ALU and writes its result back
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int NREG    = 4,
  parameter int RW      = 2,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_ra,
  input  logic [RW-1:0] instr_rb,
  input  logic          instr_imm_en,
  input  logic [DW-1:0] instr_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_s,
  input  logic [DW-1:0] alu_f,
  input  logic [5:0]    alu_flags,
  output logic [5:0]    flags,
  output logic          done,
  output logic          err,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [3:0]    r_alu_s;
  logic [RW-1:0] r_rd;
  logic [2:0]    r_cnt;
  logic [5:0]    r_flags;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_hold;
  logic [DW-1:0] w_rf_a;
  logic [DW-1:0] w_rf_b;
  logic [DW-1:0] w_opnd_b;
  logic          w_we;

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .RW   (RW)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (r_rd),
    .i_wdata    (alu_f),
    .i_ra_addr  (instr_ra),
    .o_ra_data  (w_rf_a),
    .i_rb_addr  (instr_rb),
    .o_rb_data  (w_rf_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Ready stays low through the done cycle so a queued instruction lands after writeback.
  assign instr_ready = (r_state == IDLE) && !r_done;
  assign w_accept    = instr_valid && instr_ready;
  assign w_hold      = is_hold_code(instr_op);
  assign w_opnd_b    = instr_imm_en ? instr_imm : w_rf_b;
  assign w_we        = (r_state == WB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_hold) w_next = ISSUE;
      ISSUE:   w_next = (ALU_LAT == 1) ? WB : WAIT;
      WAIT:    if (r_cnt == 3'd1) w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_s <= ALU_HOLD_CODE;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_hold) begin
              r_err <= 1'b1;
            end else begin
              r_alu_a <= w_rf_a;
              r_alu_b <= w_opnd_b;
              r_alu_s <= instr_op;
              r_rd    <= instr_rd;
            end
          end
        end
        ISSUE: begin
          r_flags <= alu_flags;
          r_cnt   <= 3'(ALU_LAT - 1);
        end
        WAIT: r_cnt <= r_cnt - 3'd1;
        WB: begin
          r_done  <= 1'b1;
          r_alu_s <= ALU_HOLD_CODE;
        end
        default: ;
      endcase
    end
  end

  assign alu_a = r_alu_a;
  assign alu_b = r_alu_b;
  assign alu_s = r_alu_s;
  assign flags = r_flags;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - directed bench for alu_issue_seq with single- and three-cycle ALU models
module tb_alu_issue_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b0, rst3 = 1'b0;
  logic       v1 = 1'b0, v3 = 1'b0;
  logic [3:0] op = 4'd0;
  logic [1:0] rd = 2'd0, ra = 2'd0, rb = 2'd0;
  logic       imm_en = 1'b0;
  logic [7:0] imm = 8'd0;
  logic [1:0] dbg1 = 2'd0, dbg3 = 2'd0;

  logic       rdy1, rdy3, done1, done3, err1, err3;
  logic [7:0] a1, b1, a3, b3, dd1, dd3;
  logic [3:0] s1, s3;
  logic [5:0] flags1, flags3, fl1, fl3;
  logic [7:0] f1 = 8'd0, f3 = 8'd0, p1 = 8'd0, p2 = 8'd0;

  int n_vec = 0;
  int n_fail = 0;

  function automatic logic [5:0] alu_flg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [5:0] f;
    s = {1'b0, a} + {1'b0, b};
    f = '0;
    f[FLG_Z]  = (s[7:0] == 8'd0);
    f[FLG_C]  = s[8];
    f[FLG_V]  = (a[7] == b[7]) && (s[7] != a[7]);
    f[FLG_EQ] = (a == b);
    f[FLG_GR] = (a > b);
    f[FLG_LS] = (a < b);
    return f;
  endfunction

  // Adder ALU models: LAT=1 honours the hold code, LAT=3 is a plain three-stage pipe.
  assign fl1 = alu_flg(a1, b1);
  assign fl3 = alu_flg(a3, b3);
  always @(posedge clk) if (s1 != ALU_HOLD_CODE) f1 <= a1 + b1;
  always @(posedge clk) begin
    p1 <= a3 + b3;
    p2 <= p1;
    f3 <= p2;
  end

  alu_issue_seq #(.DW(8), .NREG(4), .RW(2), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .instr_valid(v1), .instr_ready(rdy1), .instr_op(op),
    .instr_rd(rd), .instr_ra(ra), .instr_rb(rb), .instr_imm_en(imm_en), .instr_imm(imm),
    .alu_a(a1), .alu_b(b1), .alu_s(s1), .alu_f(f1), .alu_flags(fl1), .flags(flags1),
    .done(done1), .err(err1), .dbg_addr(dbg1), .dbg_data(dd1)
  );

  alu_issue_seq #(.DW(8), .NREG(4), .RW(2), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .instr_valid(v3), .instr_ready(rdy3), .instr_op(op),
    .instr_rd(rd), .instr_ra(ra), .instr_rb(rb), .instr_imm_en(imm_en), .instr_imm(imm),
    .alu_a(a3), .alu_b(b3), .alu_s(s3), .alu_f(f3), .alu_flags(fl3), .flags(flags3),
    .done(done3), .err(err3), .dbg_addr(dbg3), .dbg_data(dd3)
  );

  task automatic issue(input bit d3, input logic [3:0] t_op, input logic [1:0] t_rd,
                       input logic [1:0] t_ra, input logic [1:0] t_rb, input logic t_ie,
                       input logic [7:0] t_imm, output int done_at, output int rdy_low,
                       output bit stable, output logic [3:0] s_seen);
    int n;
    logic [7:0] sa, sb;
    @(negedge clk);
    op = t_op; rd = t_rd; ra = t_ra; rb = t_rb; imm_en = t_ie; imm = t_imm;
    if (d3) v3 = 1'b1; else v1 = 1'b1;
    n = 0;
    while (!(d3 ? rdy3 : rdy1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; v3 = 1'b0;
    sa = d3 ? a3 : a1;
    sb = d3 ? b3 : b1;
    s_seen = d3 ? s3 : s1;
    stable = 1'b1; done_at = 0; rdy_low = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (!(d3 ? rdy3 : rdy1)) rdy_low++;
      if (d3 ? done3 : done1) begin
        done_at = k;
        break;
      end
      if ((d3 ? a3 : a1) !== sa || (d3 ? b3 : b1) !== sb || (d3 ? s3 : s1) !== s_seen) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", rdy1); end
    n_vec++; if (done1 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got %b%b want 00", done1, err1); end
    n_vec++; if (flags1 !== 6'd0) begin n_fail++; $display("FAIL reset_flags got %b want 000000", flags1); end
    n_vec++; if (s1 !== 4'b0010 || a1 !== 8'd0 || b1 !== 8'd0) begin n_fail++; $display("FAIL reset_alu got s=%b a=%h b=%h want s=0010 a=00 b=00", s1, a1, b1); end
    n_vec++; if (s3 !== 4'b0010 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_dut3 got s=%b rdy=%b", s3, rdy3); end
    for (int i = 0; i < 4; i++) begin
      dbg1 = 2'(i); #1;
      n_vec++; if (dd1 !== 8'd0) begin n_fail++; $display("FAIL reset_reg%0d got %h want 00", i, dd1); end
    end
    @(negedge clk);
    rst1 = 1'b1; rst3 = 1'b1;
  endtask

  task automatic test_add();
    int da, rl;
    bit st;
    logic [3:0] ss;
    issue(1'b0, 4'b0001, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, da, rl, st, ss);
    issue(1'b0, 4'b0001, 2'd2, 2'd0, 2'd0, 1'b1, 8'h03, da, rl, st, ss);
    n_vec++; if (s1 !== 4'b0010) begin n_fail++; $display("FAIL add_hold_before got %b want 0010", s1); end
    issue(1'b0, 4'b0001, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, da, rl, st, ss);
    n_vec++; if (da !== 3) begin n_fail++; $display("FAIL add_latency got %0d want 3", da); end
    n_vec++; if (ss !== 4'b0001) begin n_fail++; $display("FAIL add_alu_s got %b want 0001", ss); end
    n_vec++; if (s1 !== 4'b0010) begin n_fail++; $display("FAIL add_hold_after got %b want 0010", s1); end
    n_vec++; if (flags1 !== 6'b000010) begin n_fail++; $display("FAIL add_flags got %b want 000010", flags1); end
    dbg1 = 2'd3; #1;
    n_vec++; if (dd1 !== 8'h08) begin n_fail++; $display("FAIL add_r3 got %h want 08", dd1); end
  endtask

  task automatic test_imm();
    int da, rl;
    bit st;
    logic [3:0] ss;
    issue(1'b0, 4'b0001, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, da, rl, st, ss);
    issue(1'b0, 4'b0001, 2'd0, 2'd0, 2'd3, 1'b1, 8'hFF, da, rl, st, ss);
    dbg1 = 2'd0; #1;
    n_vec++; if (dd1 !== 8'h00) begin n_fail++; $display("FAIL imm_r0 got %h want 00", dd1); end
    n_vec++; if (flags1 !== 6'b110001) begin n_fail++; $display("FAIL imm_flags got %b want 110001", flags1); end
  endtask

  task automatic test_hold_code();
    logic [7:0] exp_r [4];
    bit saw_done;
    exp_r = '{8'h00, 8'h05, 8'h03, 8'h08};
    @(negedge clk);
    op = 4'b0110; rd = 2'd1; ra = 2'd0; imm_en = 1'b1; imm = 8'h77; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    n_vec++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL hold_err_pulse got %b want 1", err1); end
    n_vec++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL hold_ready got %b want 1", rdy1); end
    @(negedge clk);
    n_vec++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL hold_err_width got %b want 0", err1); end
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL hold_no_done got %b want 0", saw_done); end
    n_vec++; if (flags1 !== 6'b110001) begin n_fail++; $display("FAIL hold_flags got %b want 110001", flags1); end
    for (int i = 0; i < 4; i++) begin
      dbg1 = 2'(i); #1;
      n_vec++; if (dd1 !== exp_r[i]) begin n_fail++; $display("FAIL hold_reg%0d got %h want %h", i, dd1, exp_r[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit saw_done, done2;
    @(negedge clk);
    op = 4'b0001; rd = 2'd1; ra = 2'd1; imm_en = 1'b1; imm = 8'h10; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd = 2'd2; ra = 2'd1; imm = 8'h01;
    k = 1; saw_done = 1'b0;
    while (!rdy1 && k < 20) begin
      if (done1) saw_done = 1'b1;
      @(negedge clk);
      k++;
    end
    n_vec++; if (k !== 4 || saw_done !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got cycle %0d done_seen %b want 4 1", k, saw_done); end
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    done2 = 1'b0;
    for (int j = 0; j < 10 && !done2; j++) begin
      if (done1) done2 = 1'b1;
      else @(negedge clk);
    end
    n_vec++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", done2); end
    dbg1 = 2'd1; #1;
    n_vec++; if (dd1 !== 8'h15) begin n_fail++; $display("FAIL b2b_r1 got %h want 15", dd1); end
    dbg1 = 2'd2; #1;
    n_vec++; if (dd1 !== 8'h16) begin n_fail++; $display("FAIL b2b_r2 got %h want 16", dd1); end
  endtask

  task automatic test_lat3();
    int da, rl;
    bit st;
    logic [3:0] ss;
    issue(1'b1, 4'b0001, 2'd1, 2'd0, 2'd0, 1'b1, 8'h07, da, rl, st, ss);
    n_vec++; if (da !== 5) begin n_fail++; $display("FAIL lat3_done got %0d want 5", da); end
    n_vec++; if (rl !== 5) begin n_fail++; $display("FAIL lat3_ready_low got %0d want 5", rl); end
    n_vec++; if (st !== 1'b1 || ss !== 4'b0001) begin n_fail++; $display("FAIL lat3_stable got %b s=%b want 1 0001", st, ss); end
    dbg3 = 2'd1; #1;
    n_vec++; if (dd3 !== 8'h07) begin n_fail++; $display("FAIL lat3_r1 got %h want 07", dd3); end
  endtask

  task automatic test_reset_mid_wait();
    int da, rl;
    bit st, saw_done;
    logic [3:0] ss;
    issue(1'b1, 4'b0001, 2'd2, 2'd0, 2'd0, 1'b1, 8'hAA, da, rl, st, ss);
    dbg3 = 2'd2; #1;
    n_vec++; if (dd3 !== 8'hAA) begin n_fail++; $display("FAIL rstw_preload got %h want AA", dd3); end
    @(negedge clk);
    op = 4'b0001; rd = 2'd2; ra = 2'd0; imm_en = 1'b1; imm = 8'h01; v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    #1 rst3 = 1'b0;
    #1;
    n_vec++; if (dd3 !== 8'h00) begin n_fail++; $display("FAIL rstw_r2 got %h want 00", dd3); end
    n_vec++; if (done3 !== 1'b0 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL rstw_state got done=%b rdy=%b want 0 1", done3, rdy3); end
    n_vec++; if (s3 !== 4'b0010) begin n_fail++; $display("FAIL rstw_alu_s got %b want 0010", s3); end
    @(negedge clk);
    rst3 = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done3) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0 || dd3 !== 8'h00) begin n_fail++; $display("FAIL rstw_no_wb got done=%b r2=%h want 0 00", saw_done, dd3); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_hold_code();
    test_back_to_back();
    test_lat3();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Upstream issue/writeback sequencer for the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from a small register file or an immediate.
- Drives the ALU's a/b/s inputs and holds them stable while the ALU result propagates.
- Captures the ALU flags, writes the registered result f back to the register file, and pulses done.

Parameters:
- DW, 8, datapath width; must match ALU operand width.
- NREG, 4, register file depth; must be a power of 2.
- RW, 2, register index width (log2 NREG).
- ALU_LAT, 1, cycles from ALU input change to valid f; legal range 1..4.

Ports:
- clk input 1 system clock, rising edge.
- rst input 1 asynchronous reset, active-low; a single clock and this reset are fixed for this block.
- instr_valid input 1 instruction offered.
- instr_ready output 1 sequencer can accept an instruction.
- instr_op input 4 ALU select code, passed to alu_s.
- instr_rd input RW destination register.
- instr_ra input RW source A register.
- instr_rb input RW source B register.
- instr_imm_en input 1 when 1, operand B comes from instr_imm.
- instr_imm input DW immediate value.
- alu_a output DW ALU operand a.
- alu_b output DW ALU operand b.
- alu_s output 4 ALU select.
- alu_f input DW ALU registered result.
- alu_flags input 6 {Z,C,V,eq,gr,ls} from the ALU.
- flags output 6 flags captured for the last completed op.
- done output 1 one-cycle pulse on writeback.
- err output 1 one-cycle pulse when an instruction is rejected.
- dbg_addr input RW debug read index.
- dbg_data output DW combinational read of regfile[dbg_addr].

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all regfile entries 0; flags=0; done=0; err=0.
  - alu_a=0, alu_b=0, alu_s=4'b0010 (the ALU hold code).
  - Any in-flight op is dropped with no writeback.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - instr_ready=1; alu_s=4'b0010 so the ALU output register holds.
  - Accept on instr_valid&&instr_ready: latch op, rd, A=regfile[ra], B=instr_imm_en ? instr_imm : regfile[rb].
  - If instr_op[1:0]==2'b10, the code is a hold code and not a legal op: pulse err next cycle, stay in IDLE, no writeback, flags unchanged.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive alu_a/alu_b/alu_s from the latched values; instr_ready=0.
  - Capture flags<=alu_flags at the end of the cycle; the flags are combinational on a/b.
  - If ALU_LAT==1 go to WB, else go to WAIT with counter=ALU_LAT-1.
- WAIT:
  - Hold alu_a/b/s stable; decrement the counter each cycle.
  - Go to WB when the counter reaches 1.
- WB (1 cycle):
  - alu_a/b/s still held; regfile[rd]<=alu_f at the end of the cycle; done=1 the following cycle.
  - Then go to IDLE.
- Latency: accept edge to done = ALU_LAT+2 clocks.
- Throughput: at most 1 instruction per ALU_LAT+2 cycles; no pipelining.
- Hazards: with one op in flight there are no hazards. An instruction whose ra==previous rd reads the written value, because acceptance occurs only in IDLE, after the write.
- Simultaneous events: rd==ra==rb is legal.
- dbg_data reads the registered array. A read during the WB cycle returns the old value; the new value appears next cycle.
- instr_* inputs are ignored when instr_ready=0; the upstream must hold them until accepted.

Decomposition:
- Shared package alu_pkg:
  - ALU_HOLD_CODE=4'b0010.
  - Flag bit indices FLG_Z..FLG_LS (5..0).
  - State enum {IDLE,ISSUE,WAIT,WB}.
  - Function is_hold_code(op) returning op[1:0]==2'b10.
- One natural sub-module: alu_regfile, NREG x DW, 1 write port, 2 read ports plus a debug read port, async-low reset.

Test Plan:
- Bench ALU model: f registered, f=a+b.
  - Preload r1=8'h05, r2=8'h03; issue op add rd=3 ra=1 rb=2.
  - Required: done exactly 3 clocks after accept (ALU_LAT=1); r3=8'h08; alu_s=4'b0010 before and after.
- instr_imm_en=1, imm=8'hFF, r0=8'h01, add rd=0 ra=0.
  - Required: r0=8'h00; flags Z=1, C=1 as presented by the model.
- instr_op=4'b0110 (op[1:0]==2'b10).
  - Required: err pulses 1 cycle; no done; regfile and flags unchanged; instr_ready stays 1.
- ALU_LAT=3.
  - Required: instr_ready low for 5 cycles after accept; alu_a/b/s stable throughout; done at accept+5.
- Assert rst=0 mid-WAIT with rd=2, r2=8'hAA.
  - Required: r2=0 immediately; no done; state IDLE; alu_s=4'b0010.
- Back-to-back: instr_valid held high with 2 instructions, the second reading the first's rd.
  - Required: the second is accepted only after done and uses the updated value.
